fifo_drain_ctrl: RTL and testbench

- Read-side controller for the transmission-layer FIFO (data_width 6, address_width 2).
- Pulls words whenever the FIFO is non-empty and consumer space exists, absorbing the FIFO's 1-cycle read latency in a 2-entry output buffer.
- Presents words downstream on a valid/ready handshake and keeps a transferred-word counter plus a sticky error flag.
- Sits between the FIFO's data_out/empty_fifo/error outputs and the next stage (demux/arbiter).

---
 rtl/fifo_drain_ctrl_pkg.sv | 16 +
 rtl/skid_buffer_2.sv | 71 +++++++
 rtl/fifo_drain_ctrl.sv | 99 +++++++++
 tb/tb_fifo_drain_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_drain_ctrl_pkg.sv
// rtl/fifo_drain_ctrl_pkg.sv - shared types and default widths for the FIFO drain controller
// Contents: drain_state_t FSM encoding, DATA_WIDTH, COUNT_WIDTH, ADDRESS_WIDTH.
package fifo_drain_ctrl_pkg;

  localparam int DATA_WIDTH    = 6;
  localparam int COUNT_WIDTH   = 8;
  // FIFO address width; the read side never needs it, it documents the FIFO depth.
  localparam int ADDRESS_WIDTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10
  } drain_state_t;

endpackage

// File: rtl/skid_buffer_2.sv
// rtl/skid_buffer_2.sv - 2-entry in-order output buffer with push/pop/occupancy
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   push, push_data : write push_data at the tail on this edge
//   pop             : drop the head on this edge (ignored when empty)
//   occupancy       : words held, 0..2
//   head_data       : oldest word held
//   overflow        : a push arrived while full without a matching pop; the word is dropped
module skid_buffer_2
  import fifo_drain_ctrl_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       occupancy,
  output logic [WIDTH-1:0] head_data,
  output logic             overflow
);

  logic [WIDTH-1:0] slot0;
  logic [WIDTH-1:0] slot1;
  logic [1:0]       occ;
  logic             pop_eff;

  assign pop_eff   = pop && (occ != 2'd0);
  assign overflow  = push && !pop_eff && (occ == 2'd2);
  assign occupancy = occ;
  assign head_data = slot0;

  // slot0 is always the head; a pop shifts slot1 forward.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot0 <= '0;
      slot1 <= '0;
      occ   <= 2'd0;
    end else begin
      case ({push, pop_eff})
        2'b10: begin
          if (occ == 2'd0) begin
            slot0 <= push_data;
          end else if (occ == 2'd1) begin
            slot1 <= push_data;
          end
          if (occ != 2'd2) begin
            occ <= occ + 2'd1;
          end
        end
        2'b01: begin
          slot0 <= slot1;
          occ   <= occ - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the head advances and the new word lands at the tail.
          if (occ == 2'd1) begin
            slot0 <= push_data;
          end else begin
            slot0 <= slot1;
            slot1 <= push_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_drain_ctrl.sv
// rtl/fifo_drain_ctrl.sv - read-side controller draining the transmission-layer FIFO
// Ports:
//   clk, reset             : clock, asynchronous active-low reset
//   enable                 : 1 = issue FIFO reads, 0 = stop reading and drain the buffer
//   empty_fifo, error      : FIFO status flags
//   data_out               : FIFO read data, valid the cycle after rd_enable
//   rd_enable              : FIFO read strobe (combinational)
//   ready_out, valid_out   : downstream handshake
//   data_o                 : head of the output buffer
//   word_count             : completed downstream transfers, wraps
//   error_sticky           : latched FIFO error or buffer overflow
module fifo_drain_ctrl
  import fifo_drain_ctrl_pkg::*;
#(
  parameter int data_width  = DATA_WIDTH,
  parameter int count_width = COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   empty_fifo,
  input  logic                   error,
  input  logic [data_width-1:0]  data_out,
  output logic                   rd_enable,
  input  logic                   ready_out,
  output logic                   valid_out,
  output logic [data_width-1:0]  data_o,
  output logic [count_width-1:0] word_count,
  output logic                   error_sticky
);

  drain_state_t state;
  drain_state_t state_nxt;
  logic         inflight;
  logic         pop;
  logic         overflow;
  logic [1:0]   occupancy;
  logic [2:0]   committed;

  assign pop       = valid_out && ready_out;
  assign valid_out = (occupancy != 2'd0);

  // Words already owned by the buffer (held or in flight) after this cycle's pop;
  // a pop this cycle frees room for a read in the same cycle.
  assign committed = {1'b0, occupancy} + {2'b00, inflight} - {2'b00, pop};

  skid_buffer_2 #(
    .WIDTH(data_width)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_data (data_out),
    .pop       (pop),
    .occupancy (occupancy),
    .head_data (data_o),
    .overflow  (overflow)
  );

  always_comb begin
    state_nxt = state;
    rd_enable = (state == RUN) && enable && !empty_fifo && (committed < 3'd2);
    case (state)
      IDLE: begin
        if (enable) state_nxt = RUN;
      end
      RUN: begin
        if (!enable) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (enable) begin
          state_nxt = RUN;
        end else if ((occupancy == 2'd0) && !inflight) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      inflight     <= 1'b0;
      word_count   <= '0;
      error_sticky <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= rd_enable;
      if (pop) begin
        word_count <= word_count + {{(count_width-1){1'b0}}, 1'b1};
      end
      if (error || overflow) begin
        error_sticky <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// tb/tb_fifo_drain_ctrl.sv - directed self-checking bench for fifo_drain_ctrl
module tb_fifo_drain_ctrl;
  import fifo_drain_ctrl_pkg::*;

  localparam int DW = DATA_WIDTH;
  localparam int CW = COUNT_WIDTH;
  localparam int FIFO_DEPTH = 1 << ADDRESS_WIDTH;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          empty_fifo = 1'b1;
  logic          error = 1'b0;
  logic          ready_out = 1'b0;
  logic [DW-1:0] data_out = '0;
  logic          rd_enable;
  logic          valid_out;
  logic [DW-1:0] data_o;
  logic [CW-1:0] word_count;
  logic          error_sticky;

  int total = 0;
  int bad = 0;

  // FIFO model: registered empty flag, read data one cycle after rd_enable.
  logic [DW-1:0] mem [0:1023];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  logic          fifo_flush = 1'b0;

  int            cyc = 0;
  int            rd_cnt = 0;
  int            viol = 0;
  logic [DW-1:0] got_q [$];
  int            pop_cyc_q [$];
  int            rd_cyc_q [$];

  fifo_drain_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .empty_fifo   (empty_fifo),
    .error        (error),
    .data_out     (data_out),
    .rd_enable    (rd_enable),
    .ready_out    (ready_out),
    .valid_out    (valid_out),
    .data_o       (data_o),
    .word_count   (word_count),
    .error_sticky (error_sticky)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifo_flush) begin
      rd_ptr     <= wr_ptr;
      empty_fifo <= 1'b1;
    end else if (rd_enable && !empty_fifo) begin
      data_out   <= mem[rd_ptr];
      rd_ptr     <= rd_ptr + 1;
      empty_fifo <= (wr_ptr == rd_ptr + 1);
    end else begin
      empty_fifo <= (wr_ptr == rd_ptr);
    end
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rd_enable) begin
      rd_cnt = rd_cnt + 1;
      rd_cyc_q.push_back(cyc);
    end
    if (rd_enable && empty_fifo) viol = viol + 1;
    if (valid_out && ready_out) begin
      got_q.push_back(data_o);
      pop_cyc_q.push_back(cyc);
    end
  end

  task automatic push_word(input logic [DW-1:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic do_reset();
    reset = 1'b0; enable = 1'b0; ready_out = 1'b0; error = 1'b0; fifo_flush = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1; fifo_flush = 1'b0;
  endtask

  task automatic test_reset();
    logic [DW-1:0] exp [3] = '{6'h05, 6'h2A, 6'h3F};
    int s0, r0;
    reset = 1'b0; enable = 1'b1; ready_out = 1'b1; error = 1'b0; fifo_flush = 1'b1;
    @(posedge clk); #1;
    fifo_flush = 1'b0;
    for (int i = 0; i < 3; i++) push_word(exp[i]);
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (rd_enable !== 1'b0) begin bad++; $display("FAIL rst_rd_enable got=%b exp=0", rd_enable); end
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL rst_valid_out got=%b exp=0", valid_out); end
    total++; if (data_o !== '0) begin bad++; $display("FAIL rst_data_o got=%h exp=00", data_o); end
    total++; if (word_count !== '0) begin bad++; $display("FAIL rst_word_count got=%0d exp=0", word_count); end
    total++; if (error_sticky !== 1'b0) begin bad++; $display("FAIL rst_error_sticky got=%b exp=0", error_sticky); end
    s0 = got_q.size(); r0 = rd_cyc_q.size();
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 20 && got_q.size() < s0 + 3; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    total++; if (got_q.size() - s0 !== 3) begin bad++; $display("FAIL rst_pop_count got=%0d exp=3", got_q.size() - s0); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (got_q.size() <= s0 + i || got_q[s0+i] !== exp[i]) begin
        bad++; $display("FAIL rst_order[%0d] got=%h exp=%h", i, (got_q.size() > s0 + i) ? got_q[s0+i] : 6'h0, exp[i]);
      end
    end
    if (pop_cyc_q.size() >= s0 + 3 && rd_cyc_q.size() > r0) begin
      total++; if (pop_cyc_q[s0+2] - pop_cyc_q[s0] !== 2) begin bad++; $display("FAIL rst_consecutive span got=%0d exp=2", pop_cyc_q[s0+2] - pop_cyc_q[s0]); end
      total++; if (pop_cyc_q[s0] - rd_cyc_q[r0] !== 2) begin bad++; $display("FAIL rst_rd_to_valid got=%0d exp=2", pop_cyc_q[s0] - rd_cyc_q[r0]); end
    end else begin
      total++; bad++; $display("FAIL rst_timing missing pops/reads got=%0d exp=3", got_q.size() - s0);
    end
    total++; if (word_count !== 8'd3) begin bad++; $display("FAIL rst_word_count3 got=%0d exp=3", word_count); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp [FIFO_DEPTH] = '{6'h01, 6'h12, 6'h23, 6'h34};
    int s0, r0;
    do_reset();
    enable = 1'b1; ready_out = 1'b0;
    r0 = rd_cnt; s0 = got_q.size();
    for (int i = 0; i < FIFO_DEPTH; i++) push_word(exp[i]);
    repeat (10) @(negedge clk);
    total++; if (rd_cnt - r0 !== 2) begin bad++; $display("FAIL bp_reads got=%0d exp=2", rd_cnt - r0); end
    total++; if (rd_enable !== 1'b0) begin bad++; $display("FAIL bp_rd_enable got=%b exp=0", rd_enable); end
    total++; if (dut.occupancy !== 2'd2) begin bad++; $display("FAIL bp_occupancy got=%0d exp=2", dut.occupancy); end
    total++; if (valid_out !== 1'b1 || data_o !== exp[0]) begin bad++; $display("FAIL bp_head got=%b/%h exp=1/%h", valid_out, data_o, exp[0]); end
    @(posedge clk); #1;
    ready_out = 1'b1;
    for (int i = 0; i < 20 && got_q.size() < s0 + FIFO_DEPTH; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      total++;
      if (got_q.size() <= s0 + i || got_q[s0+i] !== exp[i]) begin
        bad++; $display("FAIL bp_order[%0d] got=%h exp=%h", i, (got_q.size() > s0 + i) ? got_q[s0+i] : 6'h0, exp[i]);
      end
    end
    total++; if (word_count !== 8'd4) begin bad++; $display("FAIL bp_word_count got=%0d exp=4", word_count); end
    total++; if (rd_cnt - r0 !== 4) begin bad++; $display("FAIL bp_total_reads got=%0d exp=4", rd_cnt - r0); end
  endtask

  task automatic test_single_word();
    int s0, r0;
    do_reset();
    enable = 1'b1; ready_out = 1'b1;
    r0 = rd_cnt; s0 = got_q.size();
    push_word(6'h11);
    repeat (10) @(negedge clk);
    total++; if (rd_cnt - r0 !== 1) begin bad++; $display("FAIL sw_reads got=%0d exp=1", rd_cnt - r0); end
    total++; if (got_q.size() - s0 !== 1) begin bad++; $display("FAIL sw_valid_cycles got=%0d exp=1", got_q.size() - s0); end
    total++; if (got_q.size() <= s0 || got_q[s0] !== 6'h11) begin bad++; $display("FAIL sw_data got=%h exp=11", (got_q.size() > s0) ? got_q[s0] : 6'h0); end
    total++; if (viol !== 0) begin bad++; $display("FAIL sw_read_while_empty got=%0d exp=0", viol); end
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL sw_valid_after got=%b exp=0", valid_out); end
  endtask

  task automatic test_enable_drop();
    logic [DW-1:0] exp [5] = '{6'h30, 6'h31, 6'h32, 6'h33, 6'h34};
    int s0, r0, r1;
    do_reset();
    enable = 1'b1; ready_out = 1'b0;
    r0 = rd_cnt; s0 = got_q.size();
    for (int i = 0; i < 5; i++) push_word(exp[i]);
    repeat (8) @(negedge clk);
    total++; if (rd_cnt - r0 !== 2) begin bad++; $display("FAIL ed_buffered_reads got=%0d exp=2", rd_cnt - r0); end
    @(posedge clk); #1;
    ready_out = 1'b1;
    @(negedge clk);
    total++; if (rd_enable !== 1'b1) begin bad++; $display("FAIL ed_rd_before_drop got=%b exp=1", rd_enable); end
    @(posedge clk); #1;
    enable = 1'b0;
    r1 = rd_cnt;
    repeat (10) @(negedge clk);
    total++; if (rd_cnt !== r1) begin bad++; $display("FAIL ed_reads_after_drop got=%0d exp=0", rd_cnt - r1); end
    total++; if (got_q.size() - s0 !== 3) begin bad++; $display("FAIL ed_delivered got=%0d exp=3", got_q.size() - s0); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (got_q.size() <= s0 + i || got_q[s0+i] !== exp[i]) begin
        bad++; $display("FAIL ed_order[%0d] got=%h exp=%h", i, (got_q.size() > s0 + i) ? got_q[s0+i] : 6'h0, exp[i]);
      end
    end
    total++; if (dut.state !== IDLE) begin bad++; $display("FAIL ed_state got=%0d exp=%0d", dut.state, IDLE); end
    total++; if (word_count !== 8'd3) begin bad++; $display("FAIL ed_word_count got=%0d exp=3", word_count); end
  endtask

  task automatic test_error_wrap();
    int s0, errs;
    do_reset();
    @(posedge clk); #1;
    error = 1'b1;
    @(posedge clk); #1;
    error = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (error_sticky !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", error_sticky); end
    do_reset();
    @(negedge clk);
    total++; if (error_sticky !== 1'b0) begin bad++; $display("FAIL err_cleared got=%b exp=0", error_sticky); end
    enable = 1'b1; ready_out = 1'b1;
    s0 = got_q.size();
    for (int i = 0; i < 256; i++) push_word(DW'(i));
    for (int i = 0; i < 600 && got_q.size() < s0 + 256; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    total++; if (got_q.size() - s0 !== 256) begin bad++; $display("FAIL wrap_pops got=%0d exp=256", got_q.size() - s0); end
    errs = 0;
    for (int i = 0; i < 256 && s0 + i < got_q.size(); i++) if (got_q[s0+i] !== DW'(i)) errs++;
    total++; if (errs !== 0) begin bad++; $display("FAIL wrap_data got=%0d wrong exp=0", errs); end
    total++; if (word_count !== 8'd0) begin bad++; $display("FAIL wrap_word_count got=%0d exp=0", word_count); end
    if (pop_cyc_q.size() >= s0 + 256) begin
      total++; if (pop_cyc_q[s0+255] - pop_cyc_q[s0] !== 255) begin bad++; $display("FAIL wrap_throughput span got=%0d exp=255", pop_cyc_q[s0+255] - pop_cyc_q[s0]); end
    end
    total++; if (viol !== 0) begin bad++; $display("FAIL wrap_read_while_empty got=%0d exp=0", viol); end
  endtask

  task automatic test_async_reset();
    do_reset();
    enable = 1'b1; ready_out = 1'b1;
    for (int i = 0; i < 6; i++) push_word(DW'(6'h20 + i));
    @(posedge clk); #1;
    error = 1'b1;
    @(posedge clk); #1;
    error = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (valid_out !== 1'b1 || error_sticky !== 1'b1) begin bad++; $display("FAIL ar_precondition got=%b/%b exp=1/1", valid_out, error_sticky); end
    #2;
    reset = 1'b0;
    #1;
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL ar_valid_out got=%b exp=0", valid_out); end
    total++; if (data_o !== '0) begin bad++; $display("FAIL ar_data_o got=%h exp=00", data_o); end
    total++; if (word_count !== '0) begin bad++; $display("FAIL ar_word_count got=%0d exp=0", word_count); end
    total++; if (error_sticky !== 1'b0) begin bad++; $display("FAIL ar_error_sticky got=%b exp=0", error_sticky); end
    total++; if (rd_enable !== 1'b0) begin bad++; $display("FAIL ar_rd_enable got=%b exp=0", rd_enable); end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_single_word();
    test_enable_drop();
    test_error_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
